// File: rtl/plic_lite.sv
// plic_lite: APB interrupt controller with per-source priority, enable, pending, threshold and claim/complete; drives irq (int_m_ext).
// Ports: clk, rst_n (async active-low); APB slave psel/penable/pready/paddr/pwrite/pwdata/pwstrb/prdata/pslverr;
// src[k-1] is level source ID k; irq is the registered external interrupt request.
// Option PLIC_LITE_SRC_SYNC_EN: adds a 2-flop synchroniser on every src bit (src-to-irq latency 4 instead of 2).
module plic_lite #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 12,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  output logic               pready,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  input  logic [3:0]         pwstrb,
  output logic [31:0]        prdata,
  output logic               pslverr,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);
  localparam int AW = ADDR_W - 2;
  localparam int IW = 5;
  logic acc, rd, wr;
  logic [AW-1:0] wa;
  logic is_prio, is_pend, is_en, is_thr, is_clm;
  logic [31:0] rdata;
  logic [NUM_SRC:1] src_g, pend_q, pend_d, infl_q, infl_d, en_q, en_d;
  logic [NUM_SRC:1][PRIO_W-1:0] prio_q, prio_d;
  logic [PRIO_W-1:0] thr_q, thr_d, best_p;
  logic [IW-1:0] best_id;
  logic irq_q;
  logic unused_ok;
  assign unused_ok = ^{paddr[1:0], pwdata, pwstrb};
  assign acc = psel & penable;
  assign rd = acc & ~pwrite;
  assign wr = acc & pwrite;
  assign wa = paddr[ADDR_W-1:2];
  assign is_prio = wa <= AW'(NUM_SRC);
  assign is_pend = wa == AW'(32'h20);
  assign is_en = wa == AW'(32'h40);
  assign is_thr = wa == AW'(32'h60);
  assign is_clm = wa == AW'(32'h61);
  assign pready = 1'b1;
  assign pslverr = acc & ~(is_prio | is_pend | is_en | is_thr | is_clm);
  assign prdata = rd ? rdata : '0;
  assign irq = irq_q;
`ifdef PLIC_LITE_SRC_SYNC_EN
  logic [NUM_SRC:1] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= src;
      s2_q <= s1_q;
    end
  assign src_g = s2_q;
`else
  assign src_g = src;
`endif
  // Starting the running best at the threshold makes "priority > threshold" implicit;
  // strict > while scanning upward gives ties to the lowest ID.
  always_comb begin
    best_id = '0;
    best_p = thr_q;
    for (int k = 1; k <= NUM_SRC; k++)
      if (pend_q[k] && en_q[k] && prio_q[k] > best_p) begin
        best_id = IW'(k);
        best_p = prio_q[k];
      end
  end
  always_comb begin
    rdata = '0;
    for (int k = 1; k <= NUM_SRC; k++)
      if (wa == AW'(k)) rdata[PRIO_W-1:0] = prio_q[k];
    if (is_pend) rdata[NUM_SRC:1] = pend_q;
    if (is_en) rdata[NUM_SRC:1] = en_q;
    if (is_thr) rdata[PRIO_W-1:0] = thr_q;
    if (is_clm) rdata[IW-1:0] = best_id;
  end
  // Gateway sets are applied first so a same-edge claim overrides them.
  always_comb begin
    prio_d = prio_q;
    en_d = en_q;
    thr_d = thr_q;
    pend_d = pend_q | (src_g & ~infl_q);
    infl_d = infl_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (wr && wa == AW'(k) && pwstrb[0]) prio_d[k] = pwdata[PRIO_W-1:0];
      if (wr && is_en && pwstrb[k/8]) en_d[k] = pwdata[k];
      if (rd && is_clm && best_id == IW'(k)) begin
        pend_d[k] = 1'b0;
        infl_d[k] = 1'b1;
      end
      if (wr && is_clm && pwstrb[0] && pwdata[IW-1:0] == IW'(k)) infl_d[k] = 1'b0;
    end
    if (wr && is_thr && pwstrb[0]) thr_d = pwdata[PRIO_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio_q <= '0;
      en_q <= '0;
      thr_q <= '0;
      pend_q <= '0;
      infl_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
      en_q <= en_d;
      thr_q <= thr_d;
      pend_q <= pend_d;
      infl_q <= infl_d;
      irq_q <= |best_id;
    end
endmodule
